// File: rtl/channel_pkt_meta_demux.sv
// rtl/channel_pkt_meta_demux.sv - pairs metadata with packets and steers both to a channel port
// Drops out-of-range channels, discards orphan flits, keeps per-channel statistics.
module channel_pkt_meta_demux #(
  parameter int DATA_W  = 512,
  parameter int META_W  = 64,
  parameter int EMPTY_W = 6,
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_pkt_sop,
  input  logic                      in_pkt_eop,
  input  logic                      in_pkt_valid,
  input  logic [DATA_W-1:0]         in_pkt_data,
  input  logic [EMPTY_W-1:0]        in_pkt_empty,
  input  logic [CH_W-1:0]           in_pkt_channel,
  output logic                      in_pkt_ready,
  input  logic                      in_meta_valid,
  input  logic [META_W-1:0]         in_meta_data,
  input  logic [CH_W-1:0]           in_meta_channel,
  output logic                      in_meta_ready,
  output logic [NUM_CH-1:0]         out_pkt_sop,
  output logic [NUM_CH-1:0]         out_pkt_eop,
  output logic [NUM_CH-1:0]         out_pkt_valid,
  output logic [NUM_CH*DATA_W-1:0]  out_pkt_data,
  output logic [NUM_CH*EMPTY_W-1:0] out_pkt_empty,
  input  logic [NUM_CH-1:0]         out_pkt_ready,
  input  logic [NUM_CH-1:0]         out_pkt_almost_full,
  output logic [NUM_CH-1:0]         out_meta_valid,
  output logic [NUM_CH*META_W-1:0]  out_meta_data,
  input  logic [NUM_CH-1:0]         out_meta_ready,
  output logic [NUM_CH*32-1:0]      stats_pkt,
  output logic [31:0]               stats_drop,
  output logic [31:0]               stats_orphan,
  output logic [31:0]               stats_ch_mismatch
);
  typedef enum logic [1:0] {S_IDLE, S_META_OUT, S_PKT, S_DROP} state_t;
  localparam int CH_N = 1 << CH_W;

  state_t                  r_state, w_state_nxt;
  logic [META_W-1:0]       r_meta;
  logic [CH_W-1:0]         r_ch;
  logic                    r_pend;
  logic [NUM_CH-1:0][31:0] r_stats_pkt;
  logic [31:0]             r_stats_drop, r_stats_orphan, r_stats_mis;
  logic [CH_N-1:0]         w_af, w_omr, w_opr;
  logic                    w_meta_ok, w_meta_hs, w_orphan, w_pkt_done, w_mismatch, w_pend_clr;

  // Pad per-channel inputs to the full tag range so any tag value indexes safely.
  always_comb begin
    w_af  = '0;
    w_omr = '0;
    w_opr = '0;
    w_af[NUM_CH-1:0]  = out_pkt_almost_full;
    w_omr[NUM_CH-1:0] = out_meta_ready;
    w_opr[NUM_CH-1:0] = out_pkt_ready;
  end

  assign w_meta_ok = 32'(in_meta_channel) < 32'(NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    in_pkt_ready   = 1'b0;
    in_meta_ready  = 1'b0;
    out_pkt_sop    = '0;
    out_pkt_eop    = '0;
    out_pkt_valid  = '0;
    out_pkt_data   = '0;
    out_pkt_empty  = '0;
    out_meta_valid = '0;
    out_meta_data  = '0;
    w_orphan       = 1'b0;
    w_meta_hs      = 1'b0;
    w_pkt_done     = 1'b0;
    w_mismatch     = 1'b0;
    w_pend_clr     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          w_orphan      = in_pkt_valid && !in_pkt_sop;
          in_pkt_ready  = w_orphan;
          in_meta_ready = !w_orphan && !r_pend;
          if (r_pend) begin
            if (!w_af[r_ch]) begin
              w_pend_clr  = 1'b1;
              w_state_nxt = S_META_OUT;
            end
          end else if (in_meta_valid && in_meta_ready) begin
            w_meta_hs = 1'b1;
            if (!w_meta_ok)                  w_state_nxt = S_DROP;
            else if (!w_af[in_meta_channel]) w_state_nxt = S_META_OUT;
          end
        end
        S_META_OUT: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
              out_meta_valid[c]                 = 1'b1;
              out_meta_data[c*META_W +: META_W] = r_meta;
            end
          end
          if (w_omr[r_ch]) w_state_nxt = S_PKT;
        end
        S_PKT: begin
          for (int c = 0; c < NUM_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
              out_pkt_valid[c]                    = in_pkt_valid;
              out_pkt_sop[c]                      = in_pkt_sop;
              out_pkt_eop[c]                      = in_pkt_eop;
              out_pkt_data[c*DATA_W +: DATA_W]    = in_pkt_data;
              out_pkt_empty[c*EMPTY_W +: EMPTY_W] = in_pkt_empty;
            end
          end
          in_pkt_ready = w_opr[r_ch];
          if (in_pkt_valid && in_pkt_ready) begin
            w_mismatch = in_pkt_sop && (in_pkt_channel != r_ch);
            if (in_pkt_eop) begin
              w_pkt_done  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_DROP: begin
          in_pkt_ready = 1'b1;
          if (in_pkt_valid && in_pkt_eop) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta         <= '0;
      r_ch           <= '0;
      r_pend         <= 1'b0;
      r_stats_pkt    <= '0;
      r_stats_drop   <= '0;
      r_stats_orphan <= '0;
      r_stats_mis    <= '0;
    end else begin
      if (w_meta_hs) begin
        r_meta <= in_meta_data;
        r_ch   <= in_meta_channel;
        r_pend <= w_meta_ok && w_af[in_meta_channel];
      end else if (w_pend_clr) begin
        r_pend <= 1'b0;
      end
      if (w_orphan)               r_stats_orphan <= r_stats_orphan + 32'd1;
      if (w_meta_hs && !w_meta_ok) r_stats_drop  <= r_stats_drop + 32'd1;
      if (w_mismatch)             r_stats_mis    <= r_stats_mis + 32'd1;
      if (w_pkt_done) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (r_ch == CH_W'(c)) r_stats_pkt[c] <= r_stats_pkt[c] + 32'd1;
        end
      end
    end
  end

  assign stats_pkt         = r_stats_pkt;
  assign stats_drop        = r_stats_drop;
  assign stats_orphan      = r_stats_orphan;
  assign stats_ch_mismatch = r_stats_mis;
endmodule

// File: tb/tb_channel_pkt_meta_demux.sv
// tb/tb_channel_pkt_meta_demux.sv - directed self-checking bench for channel_pkt_meta_demux
module tb_channel_pkt_meta_demux;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_pkt_sop, in_pkt_eop, in_pkt_valid, in_pkt_ready;
  logic [31:0] in_pkt_data;
  logic [5:0]  in_pkt_empty;
  logic [1:0]  in_pkt_channel;
  logic        in_meta_valid, in_meta_ready;
  logic [15:0] in_meta_data;
  logic [1:0]  in_meta_channel;
  logic [1:0]  out_pkt_sop, out_pkt_eop, out_pkt_valid, out_pkt_ready, out_pkt_almost_full;
  logic [63:0] out_pkt_data;
  logic [11:0] out_pkt_empty;
  logic [1:0]  out_meta_valid, out_meta_ready;
  logic [31:0] out_meta_data;
  logic [63:0] stats_pkt;
  logic [31:0] stats_drop, stats_orphan, stats_ch_mismatch;
  int          total = 0;
  int          bad = 0;
  int          idx;
  logic [4:0]  pat;

  channel_pkt_meta_demux #(.DATA_W(32), .META_W(16), .EMPTY_W(6), .NUM_CH(2), .CH_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop), .in_pkt_valid(in_pkt_valid),
    .in_pkt_data(in_pkt_data), .in_pkt_empty(in_pkt_empty), .in_pkt_channel(in_pkt_channel),
    .in_pkt_ready(in_pkt_ready),
    .in_meta_valid(in_meta_valid), .in_meta_data(in_meta_data), .in_meta_channel(in_meta_channel),
    .in_meta_ready(in_meta_ready),
    .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_valid(out_pkt_valid),
    .out_pkt_data(out_pkt_data), .out_pkt_empty(out_pkt_empty),
    .out_pkt_ready(out_pkt_ready), .out_pkt_almost_full(out_pkt_almost_full),
    .out_meta_valid(out_meta_valid), .out_meta_data(out_meta_data), .out_meta_ready(out_meta_ready),
    .stats_pkt(stats_pkt), .stats_drop(stats_drop), .stats_orphan(stats_orphan),
    .stats_ch_mismatch(stats_ch_mismatch)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic meta(input logic [1:0] ch, input logic [15:0] d);
    in_meta_valid = 1'b1; in_meta_channel = ch; in_meta_data = d;
    #1;
    chk("meta_ready", {63'd0, in_meta_ready}, 64'd1);
    tick();
    in_meta_valid = 1'b0;
    #1;
  endtask

  task automatic flit(input logic s, input logic e, input logic [1:0] ch, input logic [31:0] d,
                      input logic [1:0] exp_ov, input logic exp_rdy);
    logic [63:0] exp_data;
    logic [11:0] exp_empty;
    exp_data  = exp_ov[0] ? {32'h0, d} : (exp_ov[1] ? {d, 32'h0} : 64'h0);
    exp_empty = exp_ov[0] ? {6'h0, d[5:0]} : (exp_ov[1] ? {d[5:0], 6'h0} : 12'h0);
    in_pkt_valid = 1'b1; in_pkt_sop = s; in_pkt_eop = e; in_pkt_channel = ch;
    in_pkt_data = d; in_pkt_empty = d[5:0];
    #1;
    chk("flit_valid", {62'd0, out_pkt_valid}, {62'd0, exp_ov});
    chk("flit_ready", {63'd0, in_pkt_ready}, {63'd0, exp_rdy});
    chk("flit_data", out_pkt_data, exp_data);
    chk("flit_empty", {52'd0, out_pkt_empty}, {52'd0, exp_empty});
    chk("flit_eop", {62'd0, out_pkt_eop}, {62'd0, exp_ov & {2{e}}});
    chk("flit_meta_ready", {63'd0, in_meta_ready}, 64'd0);
    tick();
    in_pkt_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_pkt_sop = 0; in_pkt_eop = 0; in_pkt_valid = 0; in_pkt_data = '0; in_pkt_empty = '0;
    in_pkt_channel = '0; in_meta_valid = 0; in_meta_data = '0; in_meta_channel = '0;
    out_pkt_ready = 2'b11; out_pkt_almost_full = 2'b00; out_meta_ready = 2'b11;
    tick();
    tick();
    chk("rst_meta_ready", {63'd0, in_meta_ready}, 64'd0);
    chk("rst_pkt_ready", {63'd0, in_pkt_ready}, 64'd0);
    chk("rst_meta_valid", {62'd0, out_meta_valid}, 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_stats_pkt", stats_pkt, 64'd0);
    chk("rst_stats_orphan", {32'd0, stats_orphan}, 64'd0);
    chk("idle_meta_ready", {63'd0, in_meta_ready}, 64'd1);

    // Channel 1, 3-flit packet
    meta(2'd1, 16'h00A5);
    chk("t1_mvalid", {62'd0, out_meta_valid}, 64'd2);
    chk("t1_mdata", {32'd0, out_meta_data}, {32'd0, 16'h00A5, 16'h0000});
    tick();
    flit(1, 0, 2'd1, 32'h1111_0001, 2'b10, 1);
    flit(0, 0, 2'd1, 32'h1111_0002, 2'b10, 1);
    flit(0, 1, 2'd1, 32'h1111_0003, 2'b10, 1);
    chk("t1_stats", stats_pkt, {32'd1, 32'd0});
    chk("t1_idle_valid", {62'd0, out_pkt_valid}, 64'd0);

    // Back-to-back single-flit packets on channels 0,1,0
    meta(2'd0, 16'h0200); tick(); flit(1, 1, 2'd0, 32'h2000_0001, 2'b01, 1);
    meta(2'd1, 16'h0201); tick(); flit(1, 1, 2'd1, 32'h2000_0002, 2'b10, 1);
    meta(2'd0, 16'h0202); tick(); flit(1, 1, 2'd0, 32'h2000_0003, 2'b01, 1);
    chk("t2_stats", stats_pkt, {32'd2, 32'd2});

    // Out-of-range channel dropped
    meta(2'd3, 16'h0333);
    chk("t3_no_meta", {62'd0, out_meta_valid}, 64'd0);
    flit(1, 0, 2'd3, 32'h3000_0001, 2'b00, 1);
    flit(0, 0, 2'd3, 32'h3000_0002, 2'b00, 1);
    flit(0, 0, 2'd3, 32'h3000_0003, 2'b00, 1);
    flit(0, 1, 2'd3, 32'h3000_0004, 2'b00, 1);
    chk("t3_drop", {32'd0, stats_drop}, 64'd1);
    chk("t3_stats_pkt", stats_pkt, {32'd2, 32'd2});

    // Backpressure on channel 0
    out_meta_ready = 2'b10;
    meta(2'd0, 16'h0BEE);
    for (int k = 0; k < 5; k++) begin
      chk("t4_mvalid_hold", {62'd0, out_meta_valid}, 64'd1);
      chk("t4_mdata_hold", {32'd0, out_meta_data}, 64'h0BEE);
      tick();
    end
    out_meta_ready = 2'b11;
    tick();
    idx = 0;
    pat = 5'b11010;
    for (int k = 0; k < 5; k++) begin
      in_pkt_valid = 1'b1; in_pkt_sop = (idx == 0); in_pkt_eop = (idx == 2);
      in_pkt_channel = 2'd0; in_pkt_data = 32'hB000_0000 + idx; in_pkt_empty = '0;
      out_pkt_ready = {1'b1, pat[k]};
      #1;
      chk("t4_ready_mirror", {63'd0, in_pkt_ready}, {63'd0, pat[k]});
      chk("t4_valid", {62'd0, out_pkt_valid}, 64'd1);
      chk("t4_data", out_pkt_data, {32'd0, 32'hB000_0000 + idx});
      tick();
      if (pat[k]) idx++;
    end
    in_pkt_valid = 1'b0; out_pkt_ready = 2'b11;
    #1;
    chk("t4_stats", stats_pkt, {32'd2, 32'd3});
    chk("t4_idle_valid", {62'd0, out_pkt_valid}, 64'd0);

    // Reset mid-packet: tail becomes orphans
    meta(2'd1, 16'h0C01);
    tick();
    flit(1, 0, 2'd1, 32'hC000_0001, 2'b10, 1);
    flit(0, 0, 2'd1, 32'hC000_0002, 2'b10, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_meta_ready", {63'd0, in_meta_ready}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_stats_cleared", stats_pkt, 64'd0);
    chk("t5_drop_cleared", {32'd0, stats_drop}, 64'd0);
    in_meta_valid = 1'b1; in_meta_channel = 2'd0; in_meta_data = 16'h0D00;
    flit(0, 0, 2'd1, 32'hC000_0003, 2'b00, 1);
    flit(0, 0, 2'd1, 32'hC000_0004, 2'b00, 1);
    flit(0, 1, 2'd1, 32'hC000_0005, 2'b00, 1);
    chk("t5_orphan", {32'd0, stats_orphan}, 64'd3);
    meta(2'd0, 16'h0D00);
    chk("t5_mvalid", {62'd0, out_meta_valid}, 64'd1);
    chk("t5_mdata", {32'd0, out_meta_data}, 64'h0D00);
    tick();
    flit(1, 1, 2'd0, 32'hD000_0001, 2'b01, 1);
    chk("t5_stats", stats_pkt, {32'd0, 32'd1});

    // Almost-full hold, then channel mismatch on sop
    out_pkt_almost_full = 2'b01;
    meta(2'd0, 16'h0E0E);
    for (int k = 0; k < 3; k++) begin
      chk("t6_af_no_meta", {62'd0, out_meta_valid}, 64'd0);
      chk("t6_af_meta_ready", {63'd0, in_meta_ready}, 64'd0);
      tick();
    end
    out_pkt_almost_full = 2'b00;
    tick();
    chk("t6_mvalid", {62'd0, out_meta_valid}, 64'd1);
    chk("t6_mdata", {32'd0, out_meta_data}, 64'h0E0E);
    tick();
    flit(1, 1, 2'd1, 32'hE000_0001, 2'b01, 1);
    chk("t6_mismatch", {32'd0, stats_ch_mismatch}, 64'd1);
    chk("t6_stats", stats_pkt, {32'd0, 32'd2});
    chk("t6_orphan_keep", {32'd0, stats_orphan}, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
